// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch and next-PC sequencer.
// Drives the decoder with a latched instruction and applies its PC select.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_valid,
   input  logic             stall,
   input  logic             pc_src,
   input  logic [1:0]       pc_src2,
   input  logic [31:0]      jr_target,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic [31:0]      instr,
   output logic [5:0]       opcode,
   output logic [5:0]       func,
   output logic             instr_valid,
   output logic [CNT_W-1:0] retired,
   output logic             fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] br_off;
   logic        fault_set;
   logic        retire;
   logic        load;

   assign imem_req    = (state == FETCH);
   assign imem_addr   = pc;
   assign pc_plus4    = pc + 32'd4;
   assign opcode      = instr[31:26];
   assign func        = instr[5:0];
   assign instr_valid = (state == EXEC);
   assign br_off      = {{14{instr[15]}}, instr[15:0], 2'b00};

   // Next state, next PC and fault/retire strobes; jumps outrank branches
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_plus4;
      fault_set = 1'b0;
      retire    = 1'b0;
      load      = 1'b0;
      unique case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            if (imem_valid) begin
               load      = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            if (!stall) begin
               retire    = 1'b1;
               state_nxt = FETCH;
               unique case (pc_src2)
                  2'd1: pc_nxt = {pc_plus4[31:28], instr[25:0], 2'b00};
                  2'd2: begin
                     pc_nxt    = {jr_target[31:2], 2'b00};
                     fault_set = |jr_target[1:0];
                  end
                  2'd3: fault_set = 1'b1;
                  default: begin
                     if (pc_src) pc_nxt = pc_plus4 + br_off;
                  end
               endcase
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, PC, instruction latch, saturating retire count, sticky fault
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         instr   <= '0;
         retired <= '0;
         fault   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) instr <= imem_rdata;
         if (retire) begin
            pc <= pc_nxt;
            if (retired != '1) retired <= retired + 1'b1;
         end
         if (fault_set) fault <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer.
// Stimulus pushes expected per-instruction state; a monitor checks it.
module tb_fetch_sequencer;

   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          imem_req;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_rdata;
   logic          imem_valid;
   logic          stall;
   logic          pc_src;
   logic [1:0]    pc_src2;
   logic [31:0]   jr_target;
   logic [31:0]   pc;
   logic [31:0]   pc_plus4;
   logic [31:0]   instr;
   logic [5:0]    opcode;
   logic [5:0]    func;
   logic          instr_valid;
   logic [CW-1:0] retired;
   logic          fault;

   fetch_sequencer #(
      .RESET_PC (32'h0000_0000),
      .CNT_W    (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .stall       (stall),
      .pc_src      (pc_src),
      .pc_src2     (pc_src2),
      .jr_target   (jr_target),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr       (instr),
      .opcode      (opcode),
      .func        (func),
      .instr_valid (instr_valid),
      .retired     (retired),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] ret;
      logic        flt;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mem_aa[logic [31:0]];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] pc_m;
   int          ret_m;
   logic        flt_m;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", n, act, exp);
      end
   endtask

   task automatic bad_evt(input string n);
      total++;
      bad++;
      $display("FAIL %s", n);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_aa.exists(a)) return mem_aa[a];
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] ref_next(input logic [31:0] p,
                                            input logic [31:0] w,
                                            input logic s,
                                            input logic [1:0] s2,
                                            input logic [31:0] jt);
      logic [31:0]        p4;
      logic signed [15:0] h;
      p4 = p + 32'd4;
      h  = w[15:0];
      if (s2 == 2'd1) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      if (s2 == 2'd2) return jt & 32'hFFFF_FFFC;
      if (s2 == 2'd3) return p4;
      if (s) return p4 + 32'(int'(h) * 4);
      return p4;
   endfunction

   task automatic wait_req();
      int cnt = 0;
      while (!imem_req && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      if (!imem_req) bad_evt("fetch_req_timeout");
   endtask

   task automatic run_instr(input int waitn, input int stalln,
                            input logic src, input logic [1:0] src2,
                            input logic [31:0] jt);
      exp_t        e;
      logic [31:0] w;
      w     = mem_word(pc_m);
      e.pc  = pc_m;
      e.ins = w;
      e.ret = 32'(ret_m);
      e.flt = flt_m;
      q.push_back(e);
      wait_req();
      repeat (waitn) begin
         @(posedge clk); #1;
      end
      imem_valid = 1'b1;
      imem_rdata = mem_word(imem_addr);
      @(posedge clk); #1;
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      pc_src     = src;
      pc_src2    = src2;
      jr_target  = jt;
      stall      = (stalln > 0);
      repeat (stalln) begin
         @(posedge clk); #1;
      end
      stall = 1'b0;
      @(posedge clk); #1;
      pc_src  = 1'b0;
      pc_src2 = 2'd0;
      if (src2 == 2'd3 || (src2 == 2'd2 && jt[1:0] != 2'd0)) flt_m = 1'b1;
      pc_m = ref_next(pc_m, w, src, src2, jt);
      if (ret_m != (1 << CW) - 1) ret_m++;
   endtask

   // Scoreboard monitor: fetch address and every EXEC cycle
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (imem_req && q.size() > 0) chk("fetch_addr", imem_addr, q[0].pc);
         if (instr_valid) begin
            if (q.size() == 0) begin
               bad_evt("unexpected_exec");
            end else begin
               e = q[0];
               chk("pc", pc, e.pc);
               chk("pc_plus4", pc_plus4, e.pc + 32'd4);
               chk("instr", instr, e.ins);
               chk("opcode", 32'(opcode), 32'(e.ins[31:26]));
               chk("func", 32'(func), 32'(e.ins[5:0]));
               chk("retired", 32'(retired), e.ret);
               chk("fault", 32'(fault), 32'(e.flt));
               if (!stall) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      logic [1:0] s2;
      rst        = 1'b1;
      imem_valid = 1'b0;
      imem_rdata = '0;
      stall      = 1'b0;
      pc_src     = 1'b0;
      pc_src2    = 2'd0;
      jr_target  = '0;
      pc_m       = 32'h0;
      ret_m      = 0;
      flt_m      = 1'b0;
      mem_aa[32'h0000_0000] = 32'h2008_0005;
      mem_aa[32'h0000_0004] = 32'h0000_0020;
      mem_aa[32'h0000_0010] = 32'h1000_FFFE;
      mem_aa[32'h4000_0010] = 32'h0800_0040;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_retired", 32'(retired), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      rst = 1'b0;

      run_instr(0, 0, 1'b0, 2'd0, 32'h0);
      run_instr(0, 0, 1'b0, 2'd0, 32'h0);
      chk("retired_two", 32'(retired), 32'd2);
      run_instr(3, 0, 1'b0, 2'd0, 32'h0);
      run_instr(0, 4, 1'b0, 2'd0, 32'h0);
      run_instr(0, 0, 1'b1, 2'd0, 32'h0);
      chk("beq_taken", pc, 32'h0000_000C);
      run_instr(0, 0, 1'b0, 2'd0, 32'h0);
      run_instr(0, 0, 1'b0, 2'd0, 32'h0);
      chk("beq_not_taken", pc, 32'h0000_0014);
      run_instr(0, 0, 1'b0, 2'd2, 32'h4000_0010);
      chk("jr_aligned_fault", 32'(fault), 32'h0);
      run_instr(0, 0, 1'b1, 2'd1, 32'h0);
      chk("j_over_beq", pc, 32'h4000_0100);
      run_instr(0, 0, 1'b0, 2'd2, 32'h0000_0203);
      chk("jr_misaligned_pc", pc, 32'h0000_0200);
      chk("jr_misaligned_fault", 32'(fault), 32'h1);
      run_instr(0, 0, 1'b0, 2'd3, 32'h0);
      chk("reserved_pc", pc, 32'h0000_0204);
      chk("reserved_fault", 32'(fault), 32'h1);

      for (int i = 0; i < 50; i++) begin
         r = $urandom_range(0, 9);
         s2 = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         run_instr(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                   1'($urandom_range(0, 1)), s2, $urandom);
      end
      chk("retired_saturated", 32'(retired), 32'h1F);

      wait_req();
      rst        = 1'b1;
      imem_valid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_pc", pc, 32'h0);
      chk("midrst_instr", instr, 32'h0);
      chk("midrst_valid", 32'(instr_valid), 32'h0);
      chk("midrst_req", 32'(imem_req), 32'h0);
      chk("midrst_retired", 32'(retired), 32'h0);
      chk("midrst_fault", 32'(fault), 32'h0);
      @(posedge clk); #1;
      imem_valid = 1'b0;
      chk("idle_valid_ignored", instr, 32'h0);
      chk("post_rst_req", 32'(imem_req), 32'h1);
      pc_m  = 32'h0;
      ret_m = 0;
      flt_m = 1'b0;
      run_instr(0, 0, 1'b0, 2'd0, 32'h0);
      run_instr(0, 0, 1'b0, 2'd0, 32'h0);
      chk("post_rst_pc", pc, 32'h8);
      chk("queue_drained", 32'(q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
